// File: rtl/dtengine_stream_parser_pkg.sv
// Shared DTEngine types: stream-type codes, bus widths, core line layout and
// the stream header layout used by the stream parser.
package DTEngine_Types;

    localparam int unsigned DATA_BUS_WIDTH        = 128;
    localparam int unsigned PCIE_PACKET_SIZE_BITS = 12;
    localparam int unsigned STREAM_TYPE_BITS      = 16;

    localparam logic [STREAM_TYPE_BITS-1:0] DATA_STREAM        = 16'd1;
    localparam logic [STREAM_TYPE_BITS-1:0] TREE_WEIGHT_STREAM = 16'd2;
    localparam logic [STREAM_TYPE_BITS-1:0] TREE_FINDEX_STREAM = 16'd3;
    localparam logic [STREAM_TYPE_BITS-1:0] RESULTS_STREAM     = 16'd4;

    // One line toward the core; data_valid qualifies the whole struct.
    typedef struct packed {
        logic [DATA_BUS_WIDTH-1:0] data;
        logic                      data_valid;
        logic                      last;
        logic                      prog_mode;
    } CoreDataIn;

    // Low bits of a header line; everything above is ignored.
    typedef struct packed {
        logic [PCIE_PACKET_SIZE_BITS-1:0] len;
        logic [STREAM_TYPE_BITS-1:0]      stream_type;
    } stream_hdr_t;

    localparam int unsigned HDR_BITS = $bits(stream_hdr_t);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } parser_state_e;

    // Stream types the core consumes; everything else is discarded.
    function automatic logic is_fwd_type(input logic [STREAM_TYPE_BITS-1:0] t);
        return (t == DATA_STREAM) || (t == TREE_WEIGHT_STREAM) ||
               (t == TREE_FINDEX_STREAM);
    endfunction

endpackage

// File: rtl/dtengine_stream_parser_if.sv
// Stream parser bus bundle: input line stream plus the two core-facing ports.
interface dtengine_stream_parser_if
    import DTEngine_Types::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = DTEngine_Types::DATA_BUS_WIDTH
);

    logic [DATA_BUS_WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    CoreDataIn                 data_out;
    logic                      data_ready;
    CoreDataIn                 prog_out;
    logic                      prog_ready;

    modport master (
        output in_data, in_valid, data_ready, prog_ready,
        input  in_ready, data_out, prog_out
    );

    modport slave (
        input  in_data, in_valid, data_ready, prog_ready,
        output in_ready, data_out, prog_out
    );

endinterface

// File: rtl/dtengine_out_reg.sv
// One-entry output register toward the core; holds a line until ready is seen.
module dtengine_out_reg
    import DTEngine_Types::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DATA_BUS_WIDTH-1:0] line,
    input  logic                      last,
    input  logic                      prog_mode,
    input  logic                      ready,
    output CoreDataIn                 q,
    output logic                      free_c
);

    // Room for a new line now, or once the held one leaves this cycle.
    assign free_c = !q.data_valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q.data       <= line;
            q.data_valid <= 1'b1;
            q.last       <= last;
            q.prog_mode  <= prog_mode;
        end else if (ready) begin
            q.data_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dtengine_stream_parser.sv
// Splits a header-framed line stream into feature-data and tree-programming
// streams for the core, discarding packets of unknown type.
module dtengine_stream_parser
    import DTEngine_Types::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = DTEngine_Types::DATA_BUS_WIDTH,
    parameter int unsigned LEN_BITS       = DTEngine_Types::PCIE_PACKET_SIZE_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    dtengine_stream_parser_if.slave  bus,
    output logic [31:0]              pkt_count,
    output logic [15:0]              drop_count,
    output logic                     bad_type
);

    localparam int unsigned CORE_W    = DTEngine_Types::DATA_BUS_WIDTH;
    localparam int unsigned PKT_CNT_W = 32;
    localparam int unsigned DRP_CNT_W = 16;

    logic [DATA_BUS_WIDTH-1:0] line;
    logic [CORE_W-1:0]         payload;
    stream_hdr_t               hdr;
    logic [LEN_BITS-1:0]       hdr_len;
    logic                      hdr_fwd;

    parser_state_e             state, state_nxt;
    logic [LEN_BITS-1:0]       rem, rem_nxt;
    logic                      to_prog, to_prog_nxt;
    logic                      prog_mode, prog_mode_nxt;

    logic                      ready_c;
    logic                      load_data, load_prog, line_last;
    logic                      pkt_inc, drop_inc, bad_nxt;
    logic                      data_free_c, prog_free_c;

    assign line    = DATA_BUS_WIDTH'(bus.in_data);
    assign payload = CORE_W'(line);
    assign hdr     = stream_hdr_t'(line[HDR_BITS-1:0]);
    assign hdr_len = LEN_BITS'(hdr.len);
    assign hdr_fwd = is_fwd_type(hdr.stream_type);

    assign bus.in_ready = ready_c;

    // Next-state, handshake and routing decisions.
    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        to_prog_nxt   = to_prog;
        prog_mode_nxt = prog_mode;
        ready_c       = 1'b0;
        load_data     = 1'b0;
        load_prog     = 1'b0;
        line_last     = 1'b0;
        pkt_inc       = 1'b0;
        drop_inc      = 1'b0;
        bad_nxt       = 1'b0;

        case (state)
            HDR: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    rem_nxt       = hdr_len;
                    to_prog_nxt   = (hdr.stream_type != DATA_STREAM);
                    prog_mode_nxt = (hdr.stream_type == TREE_WEIGHT_STREAM);
                    if (!hdr_fwd) begin
                        bad_nxt  = 1'b1;
                        drop_inc = 1'b1;
                    end
                    if (hdr_len != '0) begin
                        state_nxt = hdr_fwd ? FWD : DROP;
                    end
                end
            end

            FWD: begin
                ready_c = to_prog ? prog_free_c : data_free_c;
                if (bus.in_valid && ready_c) begin
                    load_data = !to_prog;
                    load_prog = to_prog;
                    line_last = (rem == LEN_BITS'(1));
                    rem_nxt   = rem - LEN_BITS'(1);
                    if (line_last) begin
                        state_nxt = HDR;
                        pkt_inc   = 1'b1;
                    end
                end
            end

            DROP: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    rem_nxt = rem - LEN_BITS'(1);
                    if (rem == LEN_BITS'(1)) begin
                        state_nxt = HDR;
                    end
                end
            end

            default: begin
                state_nxt = HDR;
            end
        endcase

        // Nothing is taken from the stream while reset is held.
        if (rst) begin
            ready_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HDR;
            rem        <= '0;
            to_prog    <= 1'b0;
            prog_mode  <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
            bad_type   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            to_prog   <= to_prog_nxt;
            prog_mode <= prog_mode_nxt;
            bad_type  <= bad_nxt;
            if (pkt_inc) begin
                pkt_count <= pkt_count + PKT_CNT_W'(1);
            end
            // Saturating so a flood of junk never reads as a small count.
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + DRP_CNT_W'(1);
            end
        end
    end

    dtengine_out_reg u_data_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_data),
        .line      (payload),
        .last      (line_last),
        .prog_mode (1'b0),
        .ready     (bus.data_ready),
        .q         (bus.data_out),
        .free_c    (data_free_c)
    );

    dtengine_out_reg u_prog_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_prog),
        .line      (payload),
        .last      (line_last),
        .prog_mode (prog_mode),
        .ready     (bus.prog_ready),
        .q         (bus.prog_out),
        .free_c    (prog_free_c)
    );

endmodule

// File: doc/dtengine_stream_parser.md
DTENGINE_STREAM_PARSER -- requirements
Module: dtengine_stream_parser

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 128: payload/header line width.
REQ-002 SHALL have parameter LEN_BITS, default 12 (PCIE_PACKET_SIZE_BITS): packet length field width, in lines.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, DATA_BUS_WIDTH: incoming stream line, header or payload.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: line accepted when in_valid && in_ready.
REQ-008 SHALL have port data_out, output, CoreDataIn: feature-data lines toward the core.
REQ-009 SHALL have port data_ready, input, 1: core accepts data_out.
REQ-010 SHALL have port prog_out, output, CoreDataIn: tree-programming lines toward the core.
REQ-011 SHALL have port prog_ready, input, 1: core accepts prog_out.
REQ-012 SHALL have port pkt_count, output, 32: forwarded packets, wraps.
REQ-013 SHALL have port drop_count, output, 16: dropped packets, saturates at 0xFFFF.
REQ-014 SHALL have port bad_type, output, 1: one-cycle pulse on a header with an unknown stream type.

Function
REQ-015 Header line layout SHALL be: [15:0] stream type; [16+LEN_BITS-1:16] payload length L in lines; remaining bits ignored.
REQ-016 FSM states SHALL be HDR, FWD, DROP; reset state is HDR.
REQ-017 In HDR, in_ready SHALL be 1; an accepted header SHALL latch type and L, and SHALL produce no output line.
REQ-018 Type DATA_STREAM (1), TREE_WEIGHT_STREAM (2) or TREE_FINDEX_STREAM (3) with L>0 SHALL go to FWD.
REQ-019 Any other type (including RESULTS_STREAM (4)) with L>0 SHALL go to DROP, pulse bad_type and increment drop_count.
REQ-020 L=0 SHALL stay in HDR; with a valid type it increments neither counter; with an invalid type it pulses bad_type and increments drop_count.
REQ-021 In FWD, the routed output SHALL be a one-entry register; in_ready = !out_valid || out_ready of the routed port.
REQ-022 An accepted payload line SHALL appear on the routed port's data field one cycle later (latency 1), with data_valid=1 and held until that port's ready is sampled high.
REQ-023 DATA_STREAM SHALL route to data_out with prog_mode=0; TREE_WEIGHT_STREAM SHALL route to prog_out with prog_mode=1; TREE_FINDEX_STREAM SHALL route to prog_out with prog_mode=0.
REQ-024 last SHALL be 1 only on the L-th payload line of a packet; after that line is accepted the FSM SHALL return to HDR and pkt_count SHALL increment.
REQ-025 The unused output port SHALL hold data_valid=0 throughout the packet.
REQ-026 In DROP, in_ready SHALL be 1; L lines SHALL be consumed and discarded, then the FSM returns to HDR.
REQ-027 A header arriving on the cycle the final line drains from the output register SHALL be accepted without a bubble; full throughput (1 line/cycle) SHALL be sustained with ready held at 1.
REQ-028 The remaining-line counter SHALL be LEN_BITS wide; L=2^LEN_BITS-1 SHALL be handled without overflow.

Reset
REQ-029 On rst assertion, asynchronously: FSM=HDR; data_out and prog_out all fields 0; counters 0; bad_type 0; in_ready 0 while rst is high.
REQ-030 Reset mid-packet SHALL discard the partial packet; the first line after deassertion SHALL be parsed as a header.

Structure
REQ-031 Stream-type constants, DATA_BUS_WIDTH, PCIE_PACKET_SIZE_BITS and the CoreDataIn struct SHALL come from the shared DTEngine_Types package; a header-field struct SHALL be added there.
REQ-032 The output register SHALL be one sub-module, dtengine_out_reg, instantiated twice (data and prog).

Verification
REQ-033 Header type=1, L=3, then lines A,B,C; readies=1 -> data_out A,B,C on consecutive cycles, last on C only, prog_mode 0, pkt_count=1.
REQ-034 Header type=2, L=2 then type=3, L=1 back-to-back -> prog_out lines with prog_mode 1,1 then 0, last on 2nd and 3rd, no bubble, pkt_count=2.
REQ-035 Header type=4, L=5 + 5 lines -> nothing output, bad_type one pulse, drop_count=1, next header parsed normally.
REQ-036 type=1, L=4, data_ready toggled 1010... -> each line held stable until accepted, no loss or duplication, in_ready low while stalled.
REQ-037 rst asserted after 2 of 4 lines of a type=2 packet -> outputs 0 immediately; next line after release is treated as a header.
REQ-038 Header type=1, L=0 -> no output, counters unchanged; 0x10000 type-7 packets -> drop_count stays 0xFFFF.
